// File: rtl/sme_pkg.sv
// Shared definitions for the string-matching-engine host side: FSM states,
// default buffer depths and the wildcard character.
package sme_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEND_S,
        SEND_P,
        WAIT,
        REPORT
    } sme_state_e;

    localparam int STR_MAX_D = 32;
    localparam int PAT_MAX_D = 8;

    localparam logic [7:0] CH_DOT = 8'h2E;

endpackage

// File: rtl/sme_char_buf.sv
// Character buffer: register array filled in order by a write counter,
// read combinationally at an arbitrary index.
module sme_char_buf #(
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH + 1),
    parameter int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          clr,
    input  logic [IW-1:0] rd_idx,
    output logic [7:0]    rd_data,
    output logic [CW-1:0] cnt,
    output logic          full
);

    logic [7:0]    mem_q [DEPTH];
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          wr_ok;

    assign full  = (cnt_q == CW'(DEPTH));
    assign wr_ok = wr_en && !clr && !full;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (wr_ok) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Contents are don't-care after reset; only the count matters.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[cnt_q[IW-1:0]] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_idx];
    assign cnt     = cnt_q;

endmodule

// File: rtl/sme_host_driver.sv
// Host-side driver for the matching engine: buffers a string and a pattern,
// streams them on start, then waits (with watchdog) for the engine result.
module sme_host_driver
    import sme_pkg::*;
#(
    parameter int STR_MAX = STR_MAX_D,
    parameter int PAT_MAX = PAT_MAX_D,
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic       wr_sel,
    input  logic [7:0] wr_data,
    input  logic       clr,
    input  logic       start,
    input  logic       keep_string,
    output logic       busy,
    output logic [7:0] chardata,
    output logic       isstring,
    output logic       ispattern,
    input  logic       valid,
    input  logic       match,
    input  logic [4:0] match_index,
    output logic       res_valid,
    output logic       res_match,
    output logic [4:0] res_index,
    output logic       res_timeout,
    output logic       err_overflow
);

    localparam int SCW = $clog2(STR_MAX + 1);
    localparam int PCW = $clog2(PAT_MAX + 1);
    localparam int SIW = $clog2(STR_MAX);
    localparam int PIW = $clog2(PAT_MAX);
    localparam int WDW = $clog2(TIMEOUT + 1);

    sme_state_e     state_q, state_d;
    logic [SIW-1:0] idx_q, idx_d;
    logic [WDW-1:0] wd_q, wd_d;
    logic           str_sent_q, str_sent_d;
    logic           err_overflow_q, err_overflow_d;
    logic           busy_q, busy_d;
    logic           isstring_q, isstring_d;
    logic           ispattern_q, ispattern_d;
    logic [7:0]     chardata_q, chardata_d;
    logic           res_valid_q, res_valid_d;
    logic           res_match_q, res_match_d;
    logic [4:0]     res_index_q, res_index_d;
    logic           res_timeout_q, res_timeout_d;

    logic           idle, clr_eff, sel_full, wr_ok, wr_drop, start_ok;
    logic           s_last, p_last;
    logic [SCW-1:0] s_cnt;
    logic [PCW-1:0] p_cnt;
    logic           s_full, p_full;
    logic [7:0]     s_rd, p_rd;

    assign idle     = (state_q == IDLE);
    assign clr_eff  = clr && idle;
    assign sel_full = wr_sel ? p_full : s_full;
    assign wr_ok    = wr_en && idle && !clr_eff && !sel_full;
    assign wr_drop  = wr_en && !clr_eff && (!idle || sel_full);

    assign start_ok = idle && start && (p_cnt != '0)
                      && ((s_cnt != '0) || (keep_string && str_sent_q));

    assign s_last = (32'(idx_q) + 32'd1 == 32'(s_cnt));
    assign p_last = (32'(idx_q) + 32'd1 == 32'(p_cnt));

    sme_char_buf #(.DEPTH(STR_MAX)) u_str_buf (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_ok && !wr_sel),
        .wr_data (wr_data),
        .clr     (clr_eff),
        .rd_idx  (idx_d),
        .rd_data (s_rd),
        .cnt     (s_cnt),
        .full    (s_full)
    );

    sme_char_buf #(.DEPTH(PAT_MAX)) u_pat_buf (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_ok && wr_sel),
        .wr_data (wr_data),
        .clr     (clr_eff),
        .rd_idx  (idx_d[PIW-1:0]),
        .rd_data (p_rd),
        .cnt     (p_cnt),
        .full    (p_full)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            wd_q           <= '0;
            str_sent_q     <= 1'b0;
            err_overflow_q <= 1'b0;
            busy_q         <= 1'b0;
            isstring_q     <= 1'b0;
            ispattern_q    <= 1'b0;
            chardata_q     <= '0;
            res_valid_q    <= 1'b0;
            res_match_q    <= 1'b0;
            res_index_q    <= '0;
            res_timeout_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            wd_q           <= wd_d;
            str_sent_q     <= str_sent_d;
            err_overflow_q <= err_overflow_d;
            busy_q         <= busy_d;
            isstring_q     <= isstring_d;
            ispattern_q    <= ispattern_d;
            chardata_q     <= chardata_d;
            res_valid_q    <= res_valid_d;
            res_match_q    <= res_match_d;
            res_index_q    <= res_index_d;
            res_timeout_q  <= res_timeout_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        wd_d           = wd_q;
        str_sent_d     = clr_eff ? 1'b0 : str_sent_q;
        err_overflow_d = clr_eff ? 1'b0 : (err_overflow_q || wr_drop);
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    idx_d   = '0;
                    state_d = keep_string ? SEND_P : SEND_S;
                end
            end
            SEND_S: begin
                if (s_last) begin
                    idx_d      = '0;
                    state_d    = SEND_P;
                    str_sent_d = 1'b1;
                end else begin
                    idx_d = idx_q + SIW'(1);
                end
            end
            SEND_P: begin
                if (p_last) begin
                    wd_d    = '0;
                    state_d = WAIT;
                end else begin
                    idx_d = idx_q + SIW'(1);
                end
            end
            WAIT: begin
                // wd_q holds the number of WAIT cycles already elapsed
                if (valid || (wd_q == WDW'(TIMEOUT))) begin
                    state_d = REPORT;
                end else begin
                    wd_d = wd_q + WDW'(1);
                end
            end
            REPORT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they appear registered.
    always_comb begin
        busy_d        = (state_d != IDLE);
        isstring_d    = 1'b0;
        ispattern_d   = 1'b0;
        chardata_d    = '0;
        res_valid_d   = 1'b0;
        res_match_d   = res_match_q;
        res_index_d   = res_index_q;
        res_timeout_d = res_timeout_q;
        case (state_d)
            SEND_S: begin
                isstring_d = 1'b1;
                chardata_d = s_rd;
            end
            SEND_P: begin
                ispattern_d = 1'b1;
                chardata_d  = p_rd;
            end
            default: ;
        endcase
        if (state_q == WAIT && state_d == REPORT) begin
            res_valid_d   = 1'b1;
            res_match_d   = valid ? match : 1'b0;
            res_index_d   = valid ? match_index : '0;
            res_timeout_d = !valid;
        end
    end

    assign busy         = busy_q;
    assign isstring     = isstring_q;
    assign ispattern    = ispattern_q;
    assign chardata     = chardata_q;
    assign res_valid    = res_valid_q;
    assign res_match    = res_match_q;
    assign res_index    = res_index_q;
    assign res_timeout  = res_timeout_q;
    assign err_overflow = err_overflow_q;

endmodule

// File: tb/tb_sme_host_driver.sv
// Scoreboard bench for sme_host_driver: queue-based string/pattern model,
// expected engine-side chars and results checked by a cycle-stamped monitor.
module tb_sme_host_driver;
    import sme_pkg::*;

    localparam int TO = 255;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0, wr_sel = 1'b0, clr = 1'b0;
    logic [7:0] wr_data = '0;
    logic       start = 1'b0, keep_string = 1'b0;
    logic       valid = 1'b0, match = 1'b0;
    logic [4:0] match_index = '0;
    logic       busy, isstring, ispattern, res_valid, res_match, res_timeout, err_overflow;
    logic [7:0] chardata;
    logic [4:0] res_index;

    sme_host_driver #(.STR_MAX(STR_MAX_D), .PAT_MAX(PAT_MAX_D), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .clr(clr), .start(start), .keep_string(keep_string), .busy(busy),
        .chardata(chardata), .isstring(isstring), .ispattern(ispattern),
        .valid(valid), .match(match), .match_index(match_index),
        .res_valid(res_valid), .res_match(res_match), .res_index(res_index),
        .res_timeout(res_timeout), .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct { int c; bit p; logic [7:0] ch; } ch_t;
    typedef struct { int c; bit m; logic [4:0] ix; bit to; } res_t;

    ch_t  exp_ch[$];
    res_t exp_res[$];
    ch_t  mon_e;
    res_t mon_r;

    // Reference model of the host-visible state
    logic [7:0] s_m[$];
    logic [7:0] p_m[$];
    bit         sent_m = 1'b0;
    bit         ovf_m = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            check("qual_excl", 32'(isstring && ispattern), 32'd0);
            if (!isstring && !ispattern) check("chardata_idle", 32'(chardata), 32'd0);
            if (isstring || ispattern) begin
                if (exp_ch.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL unexpected_char: got p=%0d data=%02h at cycle %0d, required none",
                             ispattern, chardata, cyc);
                end else begin
                    mon_e = exp_ch.pop_front();
                    check("char_cycle", cyc, mon_e.c);
                    check("char_kind", 32'(ispattern), 32'(mon_e.p));
                    check("char_data", 32'(chardata), 32'(mon_e.ch));
                end
            end
            if (res_valid) begin
                if (exp_res.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL unexpected_result: got res_valid at cycle %0d, required none", cyc);
                end else begin
                    mon_r = exp_res.pop_front();
                    check("res_cycle", cyc, mon_r.c);
                    check("res_match", 32'(res_match), 32'(mon_r.m));
                    check("res_index", 32'(res_index), 32'(mon_r.ix));
                    check("res_timeout", 32'(res_timeout), 32'(mon_r.to));
                end
            end
        end
    end

    task automatic wr(input bit sel, input logic [7:0] d);
        wr_en = 1'b1; wr_sel = sel; wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
        if (sel) begin
            if (p_m.size() == PAT_MAX_D) ovf_m = 1'b1; else p_m.push_back(d);
        end else begin
            if (s_m.size() == STR_MAX_D) ovf_m = 1'b1; else s_m.push_back(d);
        end
    endtask

    task automatic wr_text(input bit sel, input string s);
        for (int i = 0; i < s.len(); i++) wr(sel, s[i]);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        s_m.delete(); p_m.delete();
        sent_m = 1'b0; ovf_m = 1'b0;
    endtask

    task automatic run_job(input bit keep, input bit to_job, input int dly,
                           input bit m, input logic [4:0] ix, input bit junk);
        bit acc;
        int t, w, v, ns, np;
        acc = (p_m.size() > 0) && ((s_m.size() > 0) || (keep && sent_m));
        ns  = (acc && !keep) ? s_m.size() : 0;
        np  = p_m.size();
        t   = cyc;
        w   = t + ns + np + 1;
        v   = to_job ? w + TO : w + dly;
        start = 1'b1; keep_string = keep;
        if (acc) begin
            for (int i = 0; i < ns; i++) exp_ch.push_back('{t + 1 + i, 1'b0, s_m[i]});
            for (int j = 0; j < np; j++) exp_ch.push_back('{t + 1 + ns + j, 1'b1, p_m[j]});
            if (to_job) exp_res.push_back('{w + TO + 1, 1'b0, 5'd0, 1'b1});
            else        exp_res.push_back('{v + 1, m, ix, 1'b0});
        end
        @(posedge clk); #1;
        start = 1'b0; keep_string = 1'b0;
        if (!acc) begin
            for (int k = 0; k < 4; k++) begin
                check("busy_ignored", 32'(busy), 32'd0);
                @(posedge clk); #1;
            end
            $display("job t=%0d keep=%0d ignored", t, keep);
            return;
        end
        check("busy_start", 32'(busy), 32'd1);
        if (junk) begin
            // write while busy and a stray valid during the send phase
            wr_en = 1'b1; wr_sel = 1'($urandom); wr_data = 8'($urandom);
            valid = 1'b1; match = 1'b1; match_index = 5'd31;
            @(posedge clk); #1;
            wr_en = 1'b0; valid = 1'b0; match = 1'b0; match_index = '0;
            ovf_m = 1'b1;
        end
        while (cyc < v) begin @(posedge clk); #1; end
        if (!to_job) begin
            valid = 1'b1; match = m; match_index = ix;
        end
        @(posedge clk); #1;
        valid = 1'b0; match = 1'($urandom); match_index = 5'($urandom);
        check("busy_report", 32'(busy), 32'd1);
        @(posedge clk); #1;
        check("busy_end", 32'(busy), 32'd0);
        if (!keep) sent_m = 1'b1;
        check("chars_left", exp_ch.size(), 32'd0);
        check("results_left", exp_res.size(), 32'd0);
        check("err_overflow", 32'(err_overflow), 32'(ovf_m));
        $display("job t=%0d keep=%0d ns=%0d np=%0d timeout=%0d match=%0d index=%0d",
                 t, keep, ns, np, to_job, m, ix);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int t;
        int ns, np;
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_isstring", 32'(isstring), 32'd0);
        check("rst_ispattern", 32'(ispattern), 32'd0);
        check("rst_chardata", 32'(chardata), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_fields", {26'd0, res_match, res_index}, 32'd0);
        check("rst_res_timeout", 32'(res_timeout), 32'd0);
        check("rst_err_overflow", 32'(err_overflow), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // String "abcdef", pattern "cd", engine reports match at index 2
        wr_text(0, "abcdef");
        wr_text(1, "cd");
        run_job(1'b0, 1'b0, 3, 1'b1, 5'd2, 1'b0);

        // Pattern-only job reusing the string already in the engine
        do_clr();
        wr_text(0, "abcdef");
        wr(1, 8'h78);
        wr(1, CH_DOT);
        run_job(1'b0, 1'b0, 0, 1'b0, 5'd0, 1'b0);
        run_job(1'b1, 1'b0, 2, 1'b0, 5'd0, 1'b0);

        // Pattern overflow: ninth char dropped, eight sent
        do_clr();
        for (int i = 0; i < 9; i++) wr(1, 8'($urandom));
        check("ovf_set", 32'(err_overflow), 32'(ovf_m));
        wr_text(0, "hi");
        run_job(1'b0, 1'b0, 1, 1'b1, 5'd7, 1'b0);
        do_clr();
        check("ovf_clr", 32'(err_overflow), 32'(ovf_m));

        // Starts without a pattern are ignored
        wr_text(0, "abc");
        run_job(1'b0, 1'b0, 0, 1'b0, 5'd0, 1'b0);
        run_job(1'b1, 1'b0, 0, 1'b0, 5'd0, 1'b0);

        // Engine never answers: watchdog result
        wr(1, 8'h62);
        run_job(1'b0, 1'b1, 0, 1'b0, 5'd0, 1'b0);

        // Reset in the middle of the string phase
        do_clr();
        for (int i = 0; i < 10; i++) wr(0, 8'($urandom));
        wr_text(1, "zz");
        t = cyc;
        exp_ch.push_back('{t + 1, 1'b0, s_m[0]});
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        check("rstmid_isstring", 32'(isstring), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_chardata", 32'(chardata), 32'd0);
        check("rstmid_chars_seen", exp_ch.size(), 32'd0);
        exp_ch.delete(); exp_res.delete();
        s_m.delete(); p_m.delete(); sent_m = 1'b0; ovf_m = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        $display("reset mid-job at t=%0d", t);
        wr_text(1, "ab");
        run_job(1'b1, 1'b0, 0, 1'b0, 5'd0, 1'b0);
        run_job(1'b0, 1'b0, 0, 1'b0, 5'd0, 1'b0);
        wr_text(0, "qrs");
        run_job(1'b0, 1'b0, 2, 1'b1, 5'd9, 1'b0);

        // Randomised jobs, sometimes reloading, sometimes re-launching
        for (int it = 0; it < 25; it++) begin
            if (($urandom % 3 == 0) || (p_m.size() == 0)) begin
                do_clr();
                ns = $urandom_range(0, STR_MAX_D + 2);
                np = $urandom_range(0, PAT_MAX_D + 1);
                for (int i = 0; i < ns; i++) wr(0, 8'($urandom));
                for (int j = 0; j < np; j++) wr(1, 8'($urandom));
                check("rand_ovf", 32'(err_overflow), 32'(ovf_m));
            end
            run_job(1'($urandom), 1'b0, $urandom_range(0, 6), 1'($urandom),
                    5'($urandom), ($urandom % 4) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
